syscall_run_ctrl: RTL and testbench



---
 rtl/syscall_run_ctrl.sv | 132 +++++++++++++
 tb/tb_syscall_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_run_ctrl.sv
// Purpose: run control (free-run/step/halt) and hex display scanner for the MIPS core.
// Latency: pc_en is combinational; counters, print register and halted update on the exec edge.
// Backpressure: the core stalls while pc_en is low; a halt freezes the core until reset.
module syscall_run_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp,
    input  logic        halt,
    input  logic [31:0] disp_data,
    input  logic [31:0] pc_in,
    input  logic        step_mode,
    input  logic        go,
    input  logic [1:0]  sel,
    output logic        pc_en,
    output logic        halted,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    // ST_INIT is the reset encoding: it behaves as RUN or STEP according to the
    // live step_mode level, so the reset state never has to load a data input.
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]  state_q, state_d, state_cur;
    logic        go_q;
    logic        go_pulse;
    logic        exec;
    logic [31:0] print_q;
    logic [31:0] instr_cnt_q;
    logic [15:0] print_cnt_q;
    logic [15:0] presc_q;
    logic [2:0]  digit_q;
    logic [31:0] word_sel;
    logic [3:0]  nibble;
    logic [6:0]  seg_on;

    // Effective state, step edge detect, execute qualifier and next state.
    always_comb begin
        state_cur = state_q;
        if (state_q == ST_INIT) begin
            state_cur = step_mode ? ST_STEP : ST_RUN;
        end
        // The first cycle after reset only samples go, so a button held through
        // reset release cannot fire a step.
        go_pulse = go & ~go_q & (state_q != ST_INIT);
        exec     = (state_cur == ST_RUN) | ((state_cur == ST_STEP) & go_pulse);
        pc_en    = exec & ~halt;
        if (state_cur == ST_HALT || (exec && halt)) begin
            state_d = ST_HALT;
        end else begin
            state_d = step_mode ? ST_STEP : ST_RUN;
        end
    end

    assign halted = (state_q == ST_HALT);

    // Run-control state and step-button history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go;
        end
    end

    // Print register and instruction/print counters, all advanced by exec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            print_q     <= 32'd0;
            instr_cnt_q <= 32'd0;
            print_cnt_q <= 16'd0;
        end else if (exec) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
            if (disp) begin
                print_q     <= disp_data;
                print_cnt_q <= print_cnt_q + 16'd1;
            end
        end
    end

    // Digit scan prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            digit_q <= 3'd0;
        end else if (presc_q == SCAN_DIV - 16'd1) begin
            presc_q <= 16'd0;
            digit_q <= digit_q + 3'd1;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    // Display word select, nibble pick and hex font (segments g..a, active-high here).
    always_comb begin
        case (sel)
            2'd0:    word_sel = print_q;
            2'd1:    word_sel = instr_cnt_q;
            2'd2:    word_sel = {16'd0, print_cnt_q};
            default: word_sel = pc_in;
        endcase
        nibble = word_sel[{digit_q, 2'b00} +: 4];
        case (nibble)
            4'h0:    seg_on = 7'h3F;
            4'h1:    seg_on = 7'h06;
            4'h2:    seg_on = 7'h5B;
            4'h3:    seg_on = 7'h4F;
            4'h4:    seg_on = 7'h66;
            4'h5:    seg_on = 7'h6D;
            4'h6:    seg_on = 7'h7D;
            4'h7:    seg_on = 7'h07;
            4'h8:    seg_on = 7'h7F;
            4'h9:    seg_on = 7'h6F;
            4'hA:    seg_on = 7'h77;
            4'hB:    seg_on = 7'h7C;
            4'hC:    seg_on = 7'h39;
            4'hD:    seg_on = 7'h5E;
            4'hE:    seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
        seg = {1'b1, ~seg_on};
        an  = ~(8'h01 << digit_q);
    end

endmodule

// File: tb/tb_syscall_run_ctrl.sv
// Purpose: directed self-checking bench for syscall_run_ctrl.
// Latency: inputs driven at falling edges, outputs sampled away from rising edges.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_syscall_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        disp;
    logic        halt;
    logic [31:0] disp_data;
    logic [31:0] pc_in;
    logic        step_mode;
    logic        go;
    logic [1:0]  sel;
    logic        pc_en;
    logic        halted;
    logic [7:0]  an;
    logic [7:0]  seg;

    int passed = 0;
    int total  = 0;

    syscall_run_ctrl #(.SCAN_DIV(16'd2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp      (disp),
        .halt      (halt),
        .disp_data (disp_data),
        .pc_in     (pc_in),
        .step_mode (step_mode),
        .go        (go),
        .sel       (sel),
        .pc_en     (pc_en),
        .halted    (halted),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Active-low {dp,g,f,e,d,c,b,a} patterns, dp off.
    function automatic logic [7:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic wait_an(input logic [7:0] want, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (an === want) ok = 1'b1;
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] w);
        logic       ok;
        logic [7:0] one;
        logic [3:0] nib;
        for (int i = 0; i < 8; i++) begin
            one = 8'h01 << i;
            wait_an(~one, ok);
            chk({tag, "_an_reached"}, {31'd0, ok}, 32'd1);
            if (ok) begin
                nib = w[4*i +: 4];
                chk({tag, "_seg"}, {24'd0, seg}, {24'd0, font(nib)});
            end
        end
    endtask

    task automatic do_reset(input logic sm, input logic g);
        rst_n     = 1'b0;
        disp      = 1'b0;
        halt      = 1'b0;
        disp_data = 32'd0;
        go        = g;
        step_mode = sm;
        sel       = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ok;
        pc_in = 32'h0040_0010;

        // Reset values while reset is held.
        rst_n = 1'b0; disp = 1'b0; halt = 1'b0; disp_data = 32'd0;
        step_mode = 1'b0; go = 1'b0; sel = 2'd0;
        #3;
        chk("rst_an", {24'd0, an}, 32'h0000_00FE);
        chk("rst_seg", {24'd0, seg}, 32'h0000_00C0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rst_instr", dut.instr_cnt_q, 32'd0);

        // Free-run print of 0xABC, then full scan of the print register.
        do_reset(1'b0, 1'b0);
        disp = 1'b1; disp_data = 32'h0000_0ABC;
        #1 chk("print_pc_en", {31'd0, pc_en}, 32'd1);
        @(negedge clk);
        disp = 1'b0; disp_data = 32'hDEAD_BEEF;
        chk("print_reg", dut.print_q, 32'h0000_0ABC);
        chk("print_cnt", {16'd0, dut.print_cnt_q}, 32'd1);
        chk("print_instr", dut.instr_cnt_q, 32'd1);
        check_word("scan_abc", 32'h0000_0ABC);

        // Print taken in the same cycle as a switch to step mode.
        @(negedge clk);
        disp = 1'b1; disp_data = 32'h0000_0055; step_mode = 1'b1;
        @(negedge clk);
        disp = 1'b0;
        chk("toggle_print_reg", dut.print_q, 32'h0000_0055);
        chk("toggle_print_cnt", {16'd0, dut.print_cnt_q}, 32'd2);
        #1 chk("toggle_now_step", {31'd0, pc_en}, 32'd0);

        // Five plain cycles then halt, with a simultaneous step_mode change.
        do_reset(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        halt = 1'b1; step_mode = 1'b1;
        #1 chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_instr", dut.instr_cnt_q, 32'd6);
        halt = 1'b0; step_mode = 1'b0; disp = 1'b1; disp_data = 32'h0000_1234;
        #1 chk("halt_disp_pc_en", {31'd0, pc_en}, 32'd0);
        repeat (3) @(negedge clk);
        disp = 1'b0;
        chk("halt_frozen_instr", dut.instr_cnt_q, 32'd6);
        chk("halt_print_cnt", {16'd0, dut.print_cnt_q}, 32'd0);
        chk("halt_print_reg", dut.print_q, 32'd0);

        // Single-step: go held for 10 cycles gives one step, then two presses.
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("step_idle_instr", dut.instr_cnt_q, 32'd0);
        go = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1 if (pc_en) n++;
            @(negedge clk);
        end
        chk("step_held_count", n, 32'd1);
        go = 1'b0;
        repeat (2) @(negedge clk);
        go = 1'b1; @(negedge clk);
        go = 1'b0; @(negedge clk);
        go = 1'b1; @(negedge clk);
        go = 1'b0; @(negedge clk);
        chk("step_instr3", dut.instr_cnt_q, 32'd3);

        // go held through reset release: no step; then step onto halt.
        do_reset(1'b1, 1'b1);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            #1 if (pc_en) n++;
            @(negedge clk);
        end
        chk("rst_go_held_steps", n, 32'd0);
        go = 1'b0; @(negedge clk);
        go = 1'b1; halt = 1'b1;
        #1 chk("step_halt_pc_en", {31'd0, pc_en}, 32'd0);
        @(negedge clk);
        chk("step_halt_halted", {31'd0, halted}, 32'd1);
        chk("step_halt_instr", dut.instr_cnt_q, 32'd1);
        halt = 1'b0; go = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        go = 1'b1;
        #1 chk("halted_ignores_go", {31'd0, pc_en}, 32'd0);
        repeat (2) @(negedge clk);
        chk("halted_sticky", {31'd0, halted}, 32'd1);
        go = 1'b0;

        // Instruction counter wrap, then PC display.
        do_reset(1'b0, 1'b0);
        force dut.instr_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.instr_cnt_q;
        @(negedge clk);
        chk("instr_wrap", dut.instr_cnt_q, 32'd0);
        sel = 2'd3;
        check_word("scan_pc", 32'h0040_0010);

        // Asynchronous reset in the middle of a digit.
        do_reset(1'b0, 1'b0);
        disp = 1'b1; disp_data = 32'd7;
        @(negedge clk);
        disp = 1'b0; halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("pre_rst_halted", {31'd0, halted}, 32'd1);
        wait_an(8'hFD, ok);
        chk("pre_rst_digit1", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", {24'd0, an}, 32'h0000_00FE);
        chk("arst_instr", dut.instr_cnt_q, 32'd0);
        chk("arst_print_cnt", {16'd0, dut.print_cnt_q}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
